inv_reg_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one registered-inverter datapath stage between NUM_REQ requesters.

---
 rtl/inv_reg_pkg.sv | 15 +
 rtl/rr_pick.sv | 36 +++
 rtl/inv_reg_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/inv_reg_pkg.sv
// Shared types and helpers for the round-robin inverter-stage arbiter.
// Holds the FSM state encoding and the requester-id width helper.
package inv_reg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Id width never drops below one bit so a single requester still has a port.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first asserted request at or above ptr,
// wrapping from NUM_REQ-1 back to 0 (valid for non-power-of-2 NUM_REQ).
module rr_pick
    import inv_reg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    id
);

    int              idx;
    logic [ID_W-1:0] idx_l;

    always_comb begin
        found = 1'b0;
        id    = '0;
        idx   = 0;
        idx_l = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_l = ID_W'(idx);
            if (!found && req[idx_l]) begin
                found = 1'b1;
                id    = idx_l;
            end
        end
    end

endmodule

// File: rtl/inv_reg_arbiter.sv
// Round-robin sequencer sharing one external registered-inverter stage among
// NUM_REQ requesters; one transaction in flight, result returned with its id.
module inv_reg_arbiter
    import inv_reg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int INV_LAT = 1,
    parameter int CNT_W   = 2
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0] gnt,
    output logic               inv_d_in,
    input  logic               inv_d_out,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_data,
    output logic               busy
);

    if (INV_LAT < 1) begin : g_lat_chk
        $error("inv_reg_arbiter: INV_LAT must be at least 1");
    end
    if (INV_LAT >= (1 << CNT_W)) begin : g_cnt_chk
        $error("inv_reg_arbiter: CNT_W too narrow for INV_LAT");
    end

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    cur_id, cur_id_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               inv_d_in_nxt;
    logic               rsp_valid_nxt;
    logic [ID_W-1:0]    rsp_id_nxt;
    logic               rsp_data_nxt;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .id    (pick_id)
    );

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cur_id_nxt    = cur_id;
        cnt_nxt       = cnt;
        gnt_nxt       = '0;
        inv_d_in_nxt  = inv_d_in;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = rsp_id;
        rsp_data_nxt  = rsp_data;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_nxt      = NUM_REQ'(1) << pick_id;
                    inv_d_in_nxt = req_data[pick_id];
                    cur_id_nxt   = pick_id;
                    cnt_nxt      = CNT_W'(INV_LAT);
                    ptr_nxt      = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
                    state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Capture lands INV_LAT+1 edges after the grant; no regrant on this edge.
                if (cnt == '0) begin
                    rsp_data_nxt  = inv_d_out;
                    rsp_id_nxt    = cur_id;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            gnt       <= '0;
            inv_d_in  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            cur_id    <= cur_id_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            inv_d_in  <= inv_d_in_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    assign busy = (state == ST_WAIT);

endmodule
